// File: rtl/pipeline_issue.sv
// In-order issue unit: buffers instruction words in a small FIFO and releases the head
// to the register/ALU/memory pipeline once its source registers have cleared the scoreboard.
module pipeline_issue #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned HAZARD_WINDOW = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_instr,
    output logic        issue_valid,
    output logic [3:0]  func,
    output logic [3:0]  ra1,
    output logic [3:0]  ra2,
    output logic [3:0]  rwa,
    output logic [7:0]  ma,
    output logic        err_illegal,
    output logic [15:0] stall_count,
    output logic        busy
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthCnt   = CntW'(FIFO_DEPTH);
    localparam logic [2:0]      HazardInit = 3'(HAZARD_WINDOW);
    localparam logic [3:0]      FuncBubble = 4'hF;

    // Instruction buffer
    logic [23:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    // Scoreboard: cycles remaining until each register may be read again
    logic [2:0] sb_q [16];
    logic [2:0] sb_d [16];
    logic       sb_busy;

    // Registered outputs
    logic        issue_valid_q;
    logic [3:0]  func_q;
    logic [3:0]  ra1_q;
    logic [3:0]  ra2_q;
    logic [3:0]  rwa_q;
    logic [7:0]  ma_q;
    logic        err_illegal_q;
    logic [15:0] stall_count_q;
    logic        busy_q;

    logic [23:0] head;
    logic [3:0]  head_func;
    logic [3:0]  head_rwa;
    logic [3:0]  head_ra1;
    logic [3:0]  head_ra2;
    logic [7:0]  head_ma;
    logic        uses_a;
    logic        uses_b;
    logic        fifo_empty;
    logic        accept;
    logic        illegal;
    logic        push;
    logic        blocked;
    logic        pop;

    assign head      = mem_q[rd_ptr_q];
    assign head_func = head[23:20];
    assign head_rwa  = head[19:16];
    assign head_ra1  = head[15:12];
    assign head_ra2  = head[11:8];
    assign head_ma   = head[7:0];

    // Illegal opcodes never reach the buffer, so only legal ones need decoding here
    always_comb begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        unique case (head_func)
            4'h3, 4'h9, 4'hB, 4'hC: uses_b = 1'b0;
            4'h4, 4'hA:             uses_a = 1'b0;
            default: ;
        endcase
    end

    assign fifo_empty = (count_q == '0);
    assign in_ready   = (count_q != DepthCnt);
    assign accept     = in_valid && in_ready;
    assign illegal    = (in_instr[23:20] >= 4'hD);
    assign push       = accept && !illegal;
    assign blocked    = !fifo_empty &&
                        ((uses_a && (sb_q[head_ra1] != 3'd0)) ||
                         (uses_b && (sb_q[head_ra2] != 3'd0)));
    assign pop        = !fifo_empty && !blocked;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: ;
        endcase
    end

    always_comb begin
        sb_busy = 1'b0;
        for (int i = 0; i < 16; i++) begin
            sb_d[i] = 3'd0;
            if (pop && (head_rwa == 4'(i))) begin
                sb_d[i] = HazardInit;
            end else if (sb_q[i] != 3'd0) begin
                sb_d[i] = sb_q[i] - 3'd1;
            end
            if (sb_d[i] != 3'd0) begin
                sb_busy = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                sb_q[i] <= 3'd0;
            end
            issue_valid_q <= 1'b0;
            func_q        <= FuncBubble;
            ra1_q         <= 4'd0;
            ra2_q         <= 4'd0;
            rwa_q         <= 4'd0;
            ma_q          <= 8'd0;
            err_illegal_q <= 1'b0;
            stall_count_q <= 16'd0;
            busy_q        <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            for (int i = 0; i < 16; i++) begin
                sb_q[i] <= sb_d[i];
            end
            err_illegal_q <= accept && illegal;
            busy_q        <= (count_d != '0) || sb_busy;
            // Address fields hold across bubbles; downstream gates writeback on issue_valid
            if (pop) begin
                issue_valid_q <= 1'b1;
                func_q        <= head_func;
                ra1_q         <= head_ra1;
                ra2_q         <= head_ra2;
                rwa_q         <= head_rwa;
                ma_q          <= head_ma;
            end else begin
                issue_valid_q <= 1'b0;
                func_q        <= FuncBubble;
            end
            if (blocked && (stall_count_q != 16'hFFFF)) begin
                stall_count_q <= stall_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_instr;
        end
    end

    assign issue_valid = issue_valid_q;
    assign func        = func_q;
    assign ra1         = ra1_q;
    assign ra2         = ra2_q;
    assign rwa         = rwa_q;
    assign ma          = ma_q;
    assign err_illegal = err_illegal_q;
    assign stall_count = stall_count_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_pipeline_issue.sv
// Bench for pipeline_issue: directed sequences and a table of operand-masking cases,
// with every cycle also compared against a timestamp-based reference model.
module tb_pipeline_issue;

    localparam int DEPTH = 4;
    localparam int HW    = 3;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_instr;
    logic        issue_valid;
    logic [3:0]  func;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [3:0]  rwa;
    logic [7:0]  ma;
    logic        err_illegal;
    logic [15:0] stall_count;
    logic        busy;

    pipeline_issue #(
        .FIFO_DEPTH   (DEPTH),
        .HAZARD_WINDOW(HW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .issue_valid(issue_valid),
        .func       (func),
        .ra1        (ra1),
        .ra2        (ra2),
        .rwa        (rwa),
        .ma         (ma),
        .err_illegal(err_illegal),
        .stall_count(stall_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [23:0] mk(input int f, input int w, input int a, input int b,
                                       input int m);
        return {4'(f), 4'(w), 4'(a), 4'(b), 8'(m)};
    endfunction

    // Reference model: a queue for the buffer and, per register, the edge number of its
    // most recent issue. A source is readable once more than HW edges have passed.
    logic [23:0] m_fifo[$];
    int          m_last [16];
    int          m_edge;
    bit          m_acc;
    logic        m_iv;
    logic [3:0]  m_func, m_ra1, m_ra2, m_rwa;
    logic [7:0]  m_ma;
    logic        m_err;
    int          m_stall;
    logic        m_busy;

    function automatic bit reads_a(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd11, 4'd12};
    endfunction

    function automatic bit reads_b(input logic [3:0] f);
        return f inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd10};
    endfunction

    function automatic bit readable(input logic [3:0] r);
        return (m_edge - m_last[r]) > HW;
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        foreach (m_last[r]) m_last[r] = -100;
        m_edge  = 0;
        m_acc   = 0;
        m_iv    = 1'b0;
        m_func  = 4'hF;
        m_ra1   = 4'd0;
        m_ra2   = 4'd0;
        m_rwa   = 4'd0;
        m_ma    = 8'd0;
        m_err   = 1'b0;
        m_stall = 0;
        m_busy  = 1'b0;
    endtask

    task automatic model_edge();
        logic [23:0] h;
        bit          blk;
        bit          ill;
        m_edge++;
        m_acc = in_valid && (m_fifo.size() < DEPTH);
        ill   = in_instr[23:20] >= 4'd13;
        m_iv   = 1'b0;
        m_func = 4'hF;
        if (m_fifo.size() > 0) begin
            h   = m_fifo[0];
            blk = (reads_a(h[23:20]) && !readable(h[15:12])) ||
                  (reads_b(h[23:20]) && !readable(h[11:8]));
            if (blk) begin
                if (m_stall < 65535) m_stall++;
            end else begin
                void'(m_fifo.pop_front());
                m_iv   = 1'b1;
                m_func = h[23:20];
                m_rwa  = h[19:16];
                m_ra1  = h[15:12];
                m_ra2  = h[11:8];
                m_ma   = h[7:0];
                m_last[h[19:16]] = m_edge;
            end
        end
        m_err = m_acc && ill;
        if (m_acc && !ill) m_fifo.push_back(in_instr);
        m_busy = (m_fifo.size() != 0);
        foreach (m_last[r]) if (m_edge - m_last[r] < HW) m_busy = 1'b1;
    endtask

    task automatic check_model();
        chk("in_ready", 32'(in_ready), 32'(m_fifo.size() < DEPTH));
        chk("issue_valid", 32'(issue_valid), 32'(m_iv));
        chk("func", 32'(func), 32'(m_func));
        chk("ra1", 32'(ra1), 32'(m_ra1));
        chk("ra2", 32'(ra2), 32'(m_ra2));
        chk("rwa", 32'(rwa), 32'(m_rwa));
        chk("ma", 32'(ma), 32'(m_ma));
        chk("err_illegal", 32'(err_illegal), 32'(m_err));
        chk("stall_count", 32'(stall_count), 32'(m_stall));
        chk("busy", 32'(busy), 32'(m_busy));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_model();
    endtask

    task automatic push(input logic [23:0] w);
        in_valid = 1'b1;
        in_instr = w;
        step();
        in_valid = 1'b0;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        in_instr = 24'd0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [23:0] cons;
        int          gap;
    } mask_vec_t;

    localparam int NV = 14;
    mask_vec_t   vt [NV];
    logic [23:0] pend[$];
    logic [3:0]  order[$];
    logic [3:0]  bp_exp [6];
    int          gap, step_no, acc5;
    bit          got, have;
    logic [23:0] word;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        // Consumers following producer ADD r1<-r2,r3; gap = bubbles between the two issues
        vt[0]  = '{cons: mk(9, 6, 7, 1, 0),  gap: 0};
        vt[1]  = '{cons: mk(1, 4, 1, 5, 0),  gap: 3};
        vt[2]  = '{cons: mk(4, 6, 1, 5, 0),  gap: 0};
        vt[3]  = '{cons: mk(4, 6, 5, 1, 0),  gap: 3};
        vt[4]  = '{cons: mk(12, 6, 1, 5, 0), gap: 3};
        vt[5]  = '{cons: mk(10, 6, 1, 6, 0), gap: 0};
        vt[6]  = '{cons: mk(3, 6, 7, 1, 0),  gap: 0};
        vt[7]  = '{cons: mk(8, 6, 7, 1, 0),  gap: 3};
        vt[8]  = '{cons: mk(11, 6, 1, 7, 0), gap: 3};
        vt[9]  = '{cons: mk(2, 1, 2, 3, 0),  gap: 0};
        vt[10] = '{cons: mk(5, 5, 5, 5, 0),  gap: 0};
        vt[11] = '{cons: mk(6, 6, 1, 1, 0),  gap: 3};
        vt[12] = '{cons: mk(0, 6, 7, 1, 0),  gap: 3};
        vt[13] = '{cons: mk(7, 6, 1, 7, 0),  gap: 3};
        bp_exp = '{4'd1, 4'd4, 4'd10, 4'd11, 4'd12, 4'd13};

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_instr = 24'd0;
        do_reset();
        chk("reset_issue_valid", 32'(issue_valid), 32'd0);
        chk("reset_func", 32'(func), 32'hF);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_stall", 32'(stall_count), 32'd0);

        // Independent stream of four adds
        for (int i = 0; i < 4; i++) begin
            push(mk(0, i + 1, 8, 9, i));
            if (i == 0) begin
                chk("indep_first", 32'(issue_valid), 32'd0);
            end else begin
                chk("indep_valid", 32'(issue_valid), 32'd1);
                chk("indep_rwa", 32'(rwa), 32'(i));
            end
        end
        idle();
        chk("indep_valid", 32'(issue_valid), 32'd1);
        chk("indep_rwa", 32'(rwa), 32'd4);
        idle();
        chk("indep_drain", 32'(issue_valid), 32'd0);
        chk("indep_stall", 32'(stall_count), 32'd0);

        // RAW hazard: ADD r1<-r2,r3 then SUB r4<-r1,r5
        do_reset();
        push(mk(0, 1, 2, 3, 0));
        chk("raw_first", 32'(issue_valid), 32'd0);
        push(mk(1, 4, 1, 5, 0));
        chk("raw_prod", 32'(issue_valid), 32'd1);
        chk("raw_prod_rwa", 32'(rwa), 32'd1);
        for (int k = 0; k < 3; k++) begin
            idle();
            chk("raw_bubble", 32'(issue_valid), 32'd0);
            chk("raw_bubble_func", 32'(func), 32'hF);
        end
        idle();
        chk("raw_cons", 32'(issue_valid), 32'd1);
        chk("raw_cons_rwa", 32'(rwa), 32'd4);
        chk("raw_stall", 32'(stall_count), 32'd3);
        idle();
        idle();
        chk("raw_busy_tail", 32'(busy), 32'd1);
        idle();
        chk("raw_busy_clear", 32'(busy), 32'd0);
        chk("raw_stall_hold", 32'(stall_count), 32'd3);

        // Operand masking table
        for (int i = 0; i < NV; i++) begin
            do_reset();
            push(mk(0, 1, 2, 3, 0));
            push(vt[i].cons);
            gap = 0;
            got = 0;
            for (int c = 0; c < 20 && !got; c++) begin
                idle();
                if (issue_valid) got = 1;
                else gap++;
            end
            chk($sformatf("mask%0d_issued", i), 32'(got), 32'd1);
            chk($sformatf("mask%0d_gap", i), 32'(gap), 32'(vt[i].gap));
            chk($sformatf("mask%0d_func", i), 32'(func), 32'(vt[i].cons[23:20]));
            chk($sformatf("mask%0d_stall", i), 32'(stall_count), 32'(vt[i].gap));
        end

        // Backpressure behind a blocked head
        do_reset();
        pend = {mk(0, 1, 2, 3, 0), mk(1, 4, 1, 5, 0), mk(0, 10, 8, 9, 0),
                mk(0, 11, 8, 9, 0), mk(0, 12, 8, 9, 0), mk(0, 13, 8, 9, 0)};
        order.delete();
        step_no = 0;
        acc5    = -1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (pend.size() > 0);
            if (pend.size() > 0) in_instr = pend[0];
            step();
            step_no++;
            if (issue_valid) order.push_back(rwa);
            if (m_acc) begin
                if (pend.size() == 1) acc5 = step_no;
                void'(pend.pop_front());
            end
            if (step_no == 5) chk("bp_ready_full", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        chk("bp_fifth_accept_edge", 32'(acc5), 32'd7);
        chk("bp_issue_count", 32'(order.size()), 32'd6);
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            chk($sformatf("bp_order%0d", i), 32'(order[i]), 32'(bp_exp[i]));
        end

        // Illegal opcode between two valid words
        do_reset();
        push(mk(0, 1, 8, 9, 0));
        chk("ill_err0", 32'(err_illegal), 32'd0);
        push(mk(14, 7, 8, 9, 0));
        chk("ill_err1", 32'(err_illegal), 32'd1);
        chk("ill_first_rwa", 32'(rwa), 32'd1);
        push(mk(0, 2, 8, 9, 0));
        chk("ill_err_pulse", 32'(err_illegal), 32'd0);
        chk("ill_no_issue", 32'(issue_valid), 32'd0);
        idle();
        chk("ill_second", 32'(issue_valid), 32'd1);
        chk("ill_second_rwa", 32'(rwa), 32'd2);
        idle();
        chk("ill_drain", 32'(issue_valid), 32'd0);

        // Reset with three entries buffered behind a blocked head
        do_reset();
        push(mk(0, 1, 2, 3, 0));
        push(mk(1, 4, 1, 5, 1));
        push(mk(1, 5, 1, 5, 2));
        push(mk(1, 6, 1, 5, 3));
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_ready", 32'(in_ready), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(issue_valid), 32'd0);
        chk("rst_async_func", 32'(func), 32'hF);
        chk("rst_async_ra1", 32'(ra1), 32'd0);
        chk("rst_async_ra2", 32'(ra2), 32'd0);
        chk("rst_async_rwa", 32'(rwa), 32'd0);
        chk("rst_async_ma", 32'(ma), 32'd0);
        chk("rst_async_err", 32'(err_illegal), 32'd0);
        chk("rst_async_stall", 32'(stall_count), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("rst_no_stale", 32'(issue_valid), 32'd0);
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);

        // Randomized traffic against the model, two runs separated by a reset
        for (int run = 0; run < 2; run++) begin
            do_reset();
            have = 0;
            word = 24'd0;
            for (int c = 0; c < 3000; c++) begin
                if (!have && ($urandom_range(0, 3) != 0)) begin
                    have = 1;
                    word = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                            4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
                            8'($urandom_range(0, 255))};
                end
                in_valid = have;
                in_instr = word;
                step();
                if (m_acc) have = 0;
            end
            in_valid = 1'b0;
            for (int c = 0; c < 40; c++) idle();
            chk("rand_drained_busy", 32'(busy), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
